// File: rtl/shot_clock_if.sv
// Shot-clock board I/O bundle: switch inputs and the two segment digits.
// The design consumes the switches and drives the display through the slave side.
interface shot_clock_if;
    logic       pause;
    logic       mode_switch;
    logic [6:0] seg0;
    logic [6:0] seg1;

    modport master (
        output pause,
        output mode_switch,
        input  seg0,
        input  seg1
    );

    modport slave (
        input  pause,
        input  mode_switch,
        output seg0,
        output seg1
    );
endinterface

// File: rtl/shot_clock_top.sv
// Basketball shot clock: whole-second countdown from 24 or 30 to 00,
// with pause, reload on reset and two active-low seven-segment digits.
module shot_clock_top #(
    parameter int TICK_COUNT  = 50_000_000,
    parameter int SHORT_START = 24,
    parameter int LONG_START  = 30
) (
    input  logic        clk,
    input  logic        rst,
    shot_clock_if.slave io
);
    localparam int PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [PW-1:0] LAST    = PW'(TICK_COUNT - 1);
    localparam logic [4:0]    SHORT_V = 5'(SHORT_START);
    localparam logic [4:0]    LONG_V  = 5'(LONG_START);

    logic [1:0]    pause_q;
    logic [1:0]    mode_q;
    logic          pause_s;
    logic          mode_s;
    logic [4:0]    count;
    logic [PW-1:0] prescaler;
    logic          load_pending;
    logic [4:0]    tens;
    logic [4:0]    ones;

    // Synchronizers are left unreset so they settle while rst is held.
    always_ff @(posedge clk) begin
        pause_q <= {pause_q[0], io.pause};
        mode_q  <= {mode_q[0], io.mode_switch};
    end

    assign pause_s = pause_q[1];
    assign mode_s  = mode_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count        <= '0;
            prescaler    <= '0;
            load_pending <= 1'b1;
        end else if (load_pending) begin
            count        <= mode_s ? LONG_V : SHORT_V;
            prescaler    <= '0;
            load_pending <= 1'b0;
        end else if (!pause_s && count != 5'd0) begin
            if (prescaler == LAST) begin
                prescaler <= '0;
                count     <= count - 5'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [4:0] d);
        logic [6:0] s;
        case (d)
            5'd0:    s = 7'b1000000;
            5'd1:    s = 7'b1111001;
            5'd2:    s = 7'b0100100;
            5'd3:    s = 7'b0110000;
            5'd4:    s = 7'b0011001;
            5'd5:    s = 7'b0010010;
            5'd6:    s = 7'b0000010;
            5'd7:    s = 7'b1111000;
            5'd8:    s = 7'b0000000;
            5'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign tens = count / 5'd10;
    assign ones = count % 5'd10;

    assign io.seg0 = load_pending ? 7'h7F : seg7(ones);
    assign io.seg1 = load_pending ? 7'h7F : seg7(tens);
endmodule

// File: tb/tb_shot_clock_top.sv
// Shot-clock bench: expected display values are queued as stimulus is
// applied and compared against the decoded segments once the cycles elapse.
module tb_shot_clock_top;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    int   exp_q[$];

    logic [6:0] seg_tbl [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    shot_clock_if io ();

    shot_clock_top #(
        .TICK_COUNT (10),
        .SHORT_START(24),
        .LONG_START (30)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] pat(input int c);
        if (c < 0) return 14'h3FFF;
        return {seg_tbl[c / 10], seg_tbl[c % 10]};
    endfunction

    task automatic check(input string tag, input logic [13:0] got,
                         input logic [13:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b_%b expected %b_%b", tag,
                      got[13:7], got[6:0], exp[13:7], exp[6:0]);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the expected count (-1 = blank), let n cycles pass, then compare.
    task automatic sb(input string tag, input int n, input int exp);
        int e;
        exp_q.push_back(exp);
        if (n > 0) ticks(n);
        else #1;
        e = exp_q.pop_front();
        check(tag, {io.seg1, io.seg0}, pat(e));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst            = 1'b0;
        io.pause       = 1'b0;
        io.mode_switch = 1'b0;

        sb("reset_blank", 3, -1);
        rst = 1'b1;
        sb("load_24", 1, 24);
        sb("five_ticks_19", 50, 19);

        ticks(3);
        io.pause = 1'b1;
        sb("paused_19", 22, 19);
        io.pause = 1'b0;
        sb("partial_kept_15", 46, 15);
        sb("resume_14", 1, 14);

        rst = 1'b0;
        sb("async_blank", 0, -1);
        sb("held_blank", 2, -1);
        rst = 1'b1;
        sb("reload_24", 1, 24);
        sb("reload_run_19", 50, 19);

        for (int i = 1; i <= 18; i++) sb("countdown", 10, 19 - i);
        sb("last_second_01", 9, 1);
        sb("expire_00", 1, 0);
        sb("expired_hold", 100, 0);

        io.mode_switch = 1'b1;
        sb("pre_long_00", 3, 0);
        rst = 1'b0;
        sb("long_reset_blank", 2, -1);
        rst = 1'b1;
        sb("load_30", 1, 30);
        sb("long_run_25", 50, 25);
        io.mode_switch = 1'b0;
        for (int i = 1; i <= 25; i++) sb("long_countdown", 10, 25 - i);
        sb("long_expired", 50, 0);

        io.pause = 1'b1;
        ticks(3);
        rst = 1'b0;
        sb("pause_reset_blank", 2, -1);
        rst = 1'b1;
        sb("pause_load_24", 1, 24);
        sb("pause_frozen_24", 30, 24);
        io.pause = 1'b0;
        sb("unpause_23", 12, 23);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
